// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with configurable frame format and input FIFO
// Frames leave back-to-back while the FIFO holds data; every bit lasts exactly BAUD_CNT_MAX clocks.
module uart_tx_fifo #(
  parameter int UART_BPS   = 'd9600,
  parameter int CLK_FREQ   = 'd50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_flag,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam int BIT_W        = $clog2(DATA_BITS + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C   = FCNT_W'(FIFO_DEPTH);
  localparam logic              STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [FCNT_W-1:0]    count;
  logic [FCNT_W-1:0]    count_next;
  logic                 wr_en;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Full is judged on the current count, so a write while full is lost even if a pop frees a slot.
  assign wr_en = pi_flag & ~fifo_full;
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      fifo_full  <= (count_next == DEPTH_C);
      fifo_empty <= (count_next == '0);
      overflow   <= pi_flag & fifo_full;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= pi_data;
  end

  // ---------------- transmit FSM ----------------
  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     baud_cnt_next;
  logic [BIT_W-1:0]     bit_idx;
  logic [BIT_W-1:0]     bit_idx_next;
  logic                 stop_idx;
  logic                 stop_idx_next;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 par_bit;
  logic                 par_bit_next;
  logic                 tx_next;
  logic                 tx_busy_next;
  logic                 baud_wrap;
  logic                 load;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign pop       = load;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      stop_idx <= stop_idx_next;
      shift    <= shift_next;
      par_bit  <= par_bit_next;
      tx       <= tx_next;
      tx_busy  <= tx_busy_next;
    end
  end

  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    shift_next    = shift;
    par_bit_next  = par_bit;
    tx_next       = tx;
    tx_busy_next  = tx_busy;
    load          = 1'b0;

    if (state != IDLE) begin
      baud_cnt_next = baud_wrap ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (baud_wrap) begin
          state_next   = DATA;
          tx_next      = shift[0];
          shift_next   = shift >> 1;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_idx == BIT_LAST) begin
            if (PARITY != 0) begin
              state_next = PAR;
              tx_next    = par_bit;
            end else begin
              state_next    = STOP;
              tx_next       = 1'b1;
              stop_idx_next = 1'b0;
            end
          end else begin
            tx_next      = shift[0];
            shift_next   = shift >> 1;
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (baud_wrap) begin
          state_next    = STOP;
          tx_next       = 1'b1;
          stop_idx_next = 1'b0;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          if (stop_idx == STOP_LAST) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_next   = IDLE;
              tx_busy_next = 1'b0;
            end
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        tx_next      = 1'b1;
        tx_busy_next = 1'b0;
      end
    endcase

    // Start bit begins on the pop edge, from IDLE or straight out of the last stop bit.
    if (load) begin
      state_next    = START;
      baud_cnt_next = '0;
      tx_next       = 1'b0;
      tx_busy_next  = 1'b1;
      shift_next    = head;
      par_bit_next  = (PARITY == 1) ? ~(^head) : (^head);
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 sender. It adds configurable data width, optional parity and 1 or 2 stop bits. A small input FIFO lets upstream logic (sobel result streamer, debug dumpers) push bursts without waiting for each frame. Frames are sent back-to-back on tx with no idle gap while data remains queued.

Parameters:
UART_BPS, 'd9600, line baud rate.
CLK_FREQ, 'd50_000_000, sys_clk frequency in Hz; BAUD_CNT_MAX = CLK_FREQ / UART_BPS clocks per bit (integer division).
DATA_BITS, 8, payload bits per frame; legal values 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 16, input FIFO entries; power of two, at least 2.

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
sys_rst_n  in  1  asynchronous, active-low reset.
pi_data  in  DATA_BITS  byte/word to send; sampled when pi_flag=1.
pi_flag  in  1  one-cycle write strobe; may be asserted on consecutive cycles.
tx  out  1  serial line; idles high.
tx_busy  out  1  high while a frame is on the line (START through the last STOP bit).
fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
fifo_empty  out  1  FIFO holds 0 entries.
overflow  out  1  one-cycle pulse when pi_flag arrives while fifo_full=1.

Behaviour:
- Reset (async, sys_rst_n=0): tx=1, tx_busy=0, fifo_full=0, fifo_empty=1, overflow=0, FIFO count=0, FSM=IDLE, baud counter=0. Any frame in flight is abandoned and tx returns high immediately.
- FIFO write: a pi_flag with fifo_full=0 stores pi_data. A pi_flag with fifo_full=1 drops the data and pulses overflow on the next cycle.
- Full is evaluated on the current count. A write while full is dropped even if a pop happens in the same cycle.
- A simultaneous write and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Flags are registered and reflect the count after each edge. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: when fifo_empty=0, pop the head into the shift register, load baud_cnt=0, go to START. tx goes 0 on that same edge.
  - START: lasts BAUD_CNT_MAX clocks, then DATA.
  - DATA: shifts DATA_BITS bits out LSB first, each lasting BAUD_CNT_MAX clocks. Then goes to PAR if PARITY≠0, else STOP.
  - PAR: transmits the parity bit, computed over the DATA_BITS payload (XOR for even, inverted XOR for odd).
  - STOP: tx=1 for STOP_BITS × BAUD_CNT_MAX clocks.
  - At the end of STOP, if the FIFO is non-empty, pop and go directly to START on the same edge (zero idle gap). Otherwise go to IDLE.
- Latency: pi_flag at cycle N into an empty FIFO with the FSM in IDLE gives fifo_empty=0 at N+1 and tx=0 at N+2.
- tx_busy is 1 from the START edge through the final STOP clock. It is 0 in IDLE.
- The baud counter is sized $clog2(BAUD_CNT_MAX); it counts 0..BAUD_CNT_MAX-1 then wraps. Bit transitions occur only on the wrap.
- Every bit lasts exactly BAUD_CNT_MAX clocks; no half-bit or extra-bit slip is allowed across frames.
- Bit index counter is sized $clog2(DATA_BITS+1).
- Pushes during an active frame never disturb that frame; the shift register is loaded only at pop.

Test Plan:
1. CLK_FREQ=1000, UART_BPS=100 (10 clk/bit), 8N1; single pi_flag with pi_data=8'hA5 -> tx low at N+2 for 10 clk, then bits 1,0,1,0,0,1,0,1, then high 10 clk. tx_busy high for exactly 100 clk.
2. Same setup, three consecutive pi_flag with 8'h00, 8'hFF, 8'h55 -> three frames back-to-back with no idle clocks between stop and next start. fifo_empty rises only after the third pop.
3. PARITY=2 then PARITY=1, DATA_BITS=7; send 7'h03 -> parity bit 0 (even) and 1 (odd). Frame is 1+7+1+1 = 10 bits = 100 clk.
4. STOP_BITS=2, DATA_BITS=5; send 5'h1F -> stop high for 20 clk; next queued frame's start bit follows immediately after.
5. FIFO_DEPTH=4; 6 consecutive pi_flag while the FSM is busy -> 4 stored, fifo_full=1, overflow pulses twice. Only the first 4 words (plus any popped head) appear on tx, in order.
6. Assert sys_rst_n=0 mid-DATA bit 3 -> tx=1, tx_busy=0, fifo_empty=1 asynchronously. After release, a new write is sent as a clean full frame.
